// File: rtl/memtrace_lane_sequencer_if.sv
// Bundle between the memory-trace source, the sequencer and the single-port memory request channel.
// The master modport is the sequencer side; the slave modport is the source/memory side.
interface memtrace_lane_sequencer_if #(
  parameter int unsigned NUM_LANES       = 4,
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned SIZE_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
);
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_LANES-1:0]        trace_valid;
  logic [ADDR_W*NUM_LANES-1:0] trace_address;
  logic [NUM_LANES-1:0]        trace_is_store;
  logic [SIZE_W*NUM_LANES-1:0] trace_size;
  logic [DATA_W*NUM_LANES-1:0] trace_data;
  logic                        trace_finished;
  logic                        trace_ready;

  logic                        req_valid;
  logic                        req_ready;
  logic [LANE_W-1:0]           req_lane;
  logic [ADDR_W-1:0]           req_address;
  logic                        req_is_store;
  logic [SIZE_W-1:0]           req_size;
  logic [DATA_W-1:0]           req_data;

  logic                        resp_valid;
  logic [OUT_W-1:0]            outstanding;
  logic                        busy;
  logic                        done;
  logic                        resp_error;

  modport master (
    input  trace_valid, trace_address, trace_is_store, trace_size, trace_data, trace_finished,
    output trace_ready,
    output req_valid, req_lane, req_address, req_is_store, req_size, req_data,
    input  req_ready, resp_valid,
    output outstanding, busy, done, resp_error
  );

  modport slave (
    output trace_valid, trace_address, trace_is_store, trace_size, trace_data, trace_finished,
    input  trace_ready,
    input  req_valid, req_lane, req_address, req_is_store, req_size, req_data,
    output req_ready, resp_valid,
    input  outstanding, busy, done, resp_error
  );
endinterface

// File: rtl/memtrace_lane_sequencer.sv
// Captures one multi-lane trace bundle and issues its valid lanes one at a time, lowest lane first,
// limiting issued-but-unanswered requests and signalling completion once the trace has fully drained.
module memtrace_lane_sequencer #(
  parameter int unsigned NUM_LANES       = 4,
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned SIZE_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input logic                       clock,
  input logic                       reset,
  memtrace_lane_sequencer_if.master bus
);
  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [NUM_LANES-1:0] mask, mask_nxt, mask_clr;
  logic [OUT_W-1:0]     cnt, cnt_nxt;
  logic                 finished_seen, finished_nxt;
  logic                 resp_err, resp_err_nxt;
  logic                 capture, trace_rdy, req_vld, fire;
  logic [LANE_W-1:0]    sel;

  logic [ADDR_W-1:0]    cap_addr [NUM_LANES];
  logic [DATA_W-1:0]    cap_data [NUM_LANES];
  logic [SIZE_W-1:0]    cap_size [NUM_LANES];
  logic [NUM_LANES-1:0] cap_store;

  // Lowest pending lane
  always_comb begin
    sel = '0;
    for (int g = int'(NUM_LANES) - 1; g >= 0; g--) begin
      if (mask[g]) sel = LANE_W'(g);
    end
  end

  assign mask_clr = mask & ~(NUM_LANES'(1) << sel);
  assign fire     = req_vld & bus.req_ready;

  always_comb begin
    state_nxt    = state;
    mask_nxt     = mask;
    finished_nxt = finished_seen;
    capture      = 1'b0;
    trace_rdy    = 1'b0;
    req_vld      = 1'b0;
    unique case (state)
      IDLE: begin
        trace_rdy = 1'b1;
        if (|bus.trace_valid) begin
          capture      = 1'b1;
          mask_nxt     = bus.trace_valid;
          finished_nxt = bus.trace_finished;
          state_nxt    = ISSUE;
        end else if (bus.trace_finished) begin
          state_nxt = DRAIN;
        end
      end
      ISSUE: begin
        req_vld = (cnt < MAX_CNT);
        if (req_vld && bus.req_ready) begin
          mask_nxt = mask_clr;
          if (mask_clr == '0) state_nxt = finished_seen ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: ;
      default: state_nxt = IDLE;
    endcase
  end

  // In-flight count; a response with nothing in flight (and no same-cycle issue) is flagged
  always_comb begin
    cnt_nxt      = cnt;
    resp_err_nxt = resp_err;
    if (fire && !bus.resp_valid) begin
      cnt_nxt = cnt + OUT_W'(1);
    end else if (!fire && bus.resp_valid) begin
      if (cnt == '0) resp_err_nxt = 1'b1;
      else           cnt_nxt      = cnt - OUT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      mask          <= '0;
      cnt           <= '0;
      finished_seen <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      state         <= state_nxt;
      mask          <= mask_nxt;
      cnt           <= cnt_nxt;
      finished_seen <= finished_nxt;
      resp_err      <= resp_err_nxt;
    end
  end

  // Lane payloads are only meaningful under mask, so they need no reset
  always_ff @(posedge clock) begin
    if (capture) begin
      for (int g = 0; g < int'(NUM_LANES); g++) begin
        cap_addr[g] <= bus.trace_address[ADDR_W*g +: ADDR_W];
        cap_data[g] <= bus.trace_data[DATA_W*g +: DATA_W];
        cap_size[g] <= bus.trace_size[SIZE_W*g +: SIZE_W];
      end
      cap_store <= bus.trace_is_store;
    end
  end

  assign bus.trace_ready  = reset ? 1'b0 : trace_rdy;
  assign bus.req_valid    = reset ? 1'b0 : req_vld;
  assign bus.req_lane     = reset ? '0 : sel;
  assign bus.req_address  = reset ? '0 : cap_addr[sel];
  assign bus.req_data     = reset ? '0 : cap_data[sel];
  assign bus.req_size     = reset ? '0 : cap_size[sel];
  assign bus.req_is_store = reset ? 1'b0 : cap_store[sel];
  assign bus.outstanding  = reset ? '0 : cnt;
  assign bus.busy         = reset ? 1'b0 : (state == ISSUE || state == DRAIN);
  assign bus.done         = reset ? 1'b0 : (state == DONE);
  assign bus.resp_error   = reset ? 1'b0 : resp_err;
endmodule

// File: tb/tb_memtrace_lane_sequencer.sv
// Directed bench for memtrace_lane_sequencer: expected requests queued at stimulus time and
// compared by per-DUT monitors on each fire; cycle-exact status checks in the main flow.
module tb_memtrace_lane_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  memtrace_lane_sequencer_if #(.MAX_OUTSTANDING(8)) ia ();
  memtrace_lane_sequencer_if #(.MAX_OUTSTANDING(2)) ib ();

  memtrace_lane_sequencer #(.MAX_OUTSTANDING(8)) dut_a (.clock(clock), .reset(reset), .bus(ia));
  memtrace_lane_sequencer #(.MAX_OUTSTANDING(2)) dut_b (.clock(clock), .reset(reset), .bus(ib));

  typedef struct {
    logic [1:0]  lane;
    logic [63:0] addr;
    logic [63:0] data;
    logic        store;
    logic [31:0] size;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // Lane g: address 0x1000+8g, data {tag, g}, size (1<<g)+tag, store = g[0]^tag[0]
  task automatic offer(input bit to_b, input logic [3:0] v, input logic fin,
                       input logic [3:0] expect_mask, input logic [7:0] tag);
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      e.lane  = 2'(g);
      e.addr  = 64'h1000 + 64'(8 * g);
      e.data  = {32'(tag), 32'(g)};
      e.size  = 32'(1 << g) + 32'(tag);
      e.store = 1'(g) ^ tag[0];
      if (to_b) begin
        ib.trace_address[64*g +: 64] = e.addr;
        ib.trace_data[64*g +: 64]    = e.data;
        ib.trace_size[32*g +: 32]    = e.size;
        ib.trace_is_store[g]         = e.store;
        if (expect_mask[g]) exp_b.push_back(e);
      end else begin
        ia.trace_address[64*g +: 64] = e.addr;
        ia.trace_data[64*g +: 64]    = e.data;
        ia.trace_size[32*g +: 32]    = e.size;
        ia.trace_is_store[g]         = e.store;
        if (expect_mask[g]) exp_a.push_back(e);
      end
    end
    if (to_b) begin ib.trace_valid = v; ib.trace_finished = fin; end
    else      begin ia.trace_valid = v; ia.trace_finished = fin; end
  endtask

  // Withdraw the bundle and scramble payloads; captured values must not follow
  task automatic withdraw(input bit to_b);
    if (to_b) begin
      ib.trace_valid = '0; ib.trace_finished = 1'b0;
      ib.trace_address = '1; ib.trace_data = '1; ib.trace_size = '1; ib.trace_is_store = '1;
    end else begin
      ia.trace_valid = '0; ia.trace_finished = 1'b0;
      ia.trace_address = '1; ia.trace_data = '1; ia.trace_size = '1; ia.trace_is_store = '1;
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && ia.req_valid && ia.req_ready) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_req: got lane %0d expected no request", ia.req_lane);
      end else begin
        e = exp_a.pop_front();
        chk("a_req_lane", 64'(ia.req_lane), 64'(e.lane));
        chk("a_req_address", ia.req_address, e.addr);
        chk("a_req_data", ia.req_data, e.data);
        chk("a_req_size", 64'(ia.req_size), 64'(e.size));
        chk("a_req_is_store", 64'(ia.req_is_store), 64'(e.store));
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && ib.req_valid && ib.req_ready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_req: got lane %0d expected no request", ib.req_lane);
      end else begin
        e = exp_b.pop_front();
        chk("b_req_lane", 64'(ib.req_lane), 64'(e.lane));
        chk("b_req_address", ib.req_address, e.addr);
        chk("b_req_data", ib.req_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    withdraw(1'b0); withdraw(1'b1);
    ia.req_ready = 1'b0; ia.resp_valid = 1'b0;
    ib.req_ready = 1'b0; ib.resp_valid = 1'b0;

    // Reset: every output held at zero
    tick(); sample();
    chk("rst_trace_ready", 64'(ia.trace_ready), 0);
    chk("rst_req_valid", 64'(ia.req_valid), 0);
    chk("rst_outstanding", 64'(ia.outstanding), 0);
    chk("rst_busy", 64'(ia.busy), 0);
    chk("rst_done", 64'(ia.done), 0);
    chk("rst_resp_error", 64'(ia.resp_error), 0);
    tick(); reset = 1'b0; ia.req_ready = 1'b1; ib.req_ready = 1'b1; sample();
    chk("idle_trace_ready", 64'(ia.trace_ready), 1);
    chk("idle_busy", 64'(ia.busy), 0);

    // 1: valid 1011 at full rate -> lanes 0,1,3 then ready again
    tick(); offer(1'b0, 4'b1011, 1'b0, 4'b1011, 8'h11); sample();
    chk("t1_accept_ready", 64'(ia.trace_ready), 1);
    tick(); withdraw(1'b0); sample();
    chk("t1_n1_valid", 64'(ia.req_valid), 1);
    chk("t1_n1_lane", 64'(ia.req_lane), 0);
    chk("t1_n1_ready", 64'(ia.trace_ready), 0);
    chk("t1_n1_busy", 64'(ia.busy), 1);
    tick(); sample(); chk("t1_n2_lane", 64'(ia.req_lane), 1);
    tick(); sample(); chk("t1_n3_lane", 64'(ia.req_lane), 3);
    tick(); sample();
    chk("t1_n4_ready", 64'(ia.trace_ready), 1);
    chk("t1_n4_valid", 64'(ia.req_valid), 0);
    chk("t1_n4_outstanding", 64'(ia.outstanding), 3);
    tick(); ia.resp_valid = 1'b1; tick(); tick(); tick(); ia.resp_valid = 1'b0; sample();
    chk("t1_drained", 64'(ia.outstanding), 0);

    // 2: valid 1111, stall 3 cycles on lane 2
    tick(); offer(1'b0, 4'b1111, 1'b0, 4'b1111, 8'h22); sample();
    chk("t2_accept_ready", 64'(ia.trace_ready), 1);
    tick(); withdraw(1'b0); sample(); chk("t2_n1_lane", 64'(ia.req_lane), 0);
    tick(); sample(); chk("t2_n2_lane", 64'(ia.req_lane), 1);
    tick(); ia.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      sample();
      chk("t2_stall_valid", 64'(ia.req_valid), 1);
      chk("t2_stall_lane", 64'(ia.req_lane), 2);
      chk("t2_stall_address", ia.req_address, 64'h1010);
    end
    tick(); ia.req_ready = 1'b1; sample(); chk("t2_release_lane", 64'(ia.req_lane), 2);
    tick(); sample(); chk("t2_last_lane", 64'(ia.req_lane), 3);
    tick(); sample();
    chk("t2_outstanding", 64'(ia.outstanding), 4);
    chk("t2_ready", 64'(ia.trace_ready), 1);

    // 4: fire with same-cycle response, then a stray response
    tick(); ia.resp_valid = 1'b1; tick(); tick(); tick(); tick(); ia.resp_valid = 1'b0; sample();
    chk("t4_drained", 64'(ia.outstanding), 0);
    tick(); offer(1'b0, 4'b0011, 1'b0, 4'b0011, 8'h44); sample();
    tick(); withdraw(1'b0); sample(); chk("t4_n1_lane", 64'(ia.req_lane), 0);
    tick(); ia.resp_valid = 1'b1; sample();
    chk("t4_n2_lane", 64'(ia.req_lane), 1);
    chk("t4_n2_outstanding", 64'(ia.outstanding), 1);
    tick(); ia.resp_valid = 1'b0; sample();
    chk("t4_fire_resp_net", 64'(ia.outstanding), 1);
    chk("t4_no_error_yet", 64'(ia.resp_error), 0);
    tick(); ia.resp_valid = 1'b1; sample();
    tick(); sample();
    chk("t4_zero", 64'(ia.outstanding), 0);
    chk("t4_error_clear", 64'(ia.resp_error), 0);
    tick(); ia.resp_valid = 1'b0; sample();
    chk("t4_error_set", 64'(ia.resp_error), 1);
    chk("t4_floor_zero", 64'(ia.outstanding), 0);
    tick(); tick(); sample();
    chk("t4_error_sticky", 64'(ia.resp_error), 1);

    // 5: single lane with finished, 3-cycle response latency
    tick(); offer(1'b0, 4'b0001, 1'b1, 4'b0001, 8'h55); sample();
    chk("t5_accept_ready", 64'(ia.trace_ready), 1);
    tick(); withdraw(1'b0); sample(); chk("t5_n1_valid", 64'(ia.req_valid), 1);
    tick(); sample();
    chk("t5_drain_busy", 64'(ia.busy), 1);
    chk("t5_drain_valid", 64'(ia.req_valid), 0);
    chk("t5_drain_ready", 64'(ia.trace_ready), 0);
    chk("t5_drain_outstanding", 64'(ia.outstanding), 1);
    tick(); sample();
    tick(); ia.resp_valid = 1'b1; sample(); chk("t5_n4_done", 64'(ia.done), 0);
    tick(); ia.resp_valid = 1'b0; sample();
    chk("t5_n5_done", 64'(ia.done), 0);
    chk("t5_n5_outstanding", 64'(ia.outstanding), 0);
    tick(); offer(1'b0, 4'b1111, 1'b0, 4'b0000, 8'h5A); sample();
    chk("t5_done", 64'(ia.done), 1);
    chk("t5_done_busy", 64'(ia.busy), 0);
    chk("t5_done_ready", 64'(ia.trace_ready), 0);
    tick(); tick(); sample();
    chk("t5_done_held", 64'(ia.done), 1);
    chk("t5_done_no_req", 64'(ia.req_valid), 0);
    withdraw(1'b0);

    // 6: reset while lanes 2,3 are still pending
    tick(); reset = 1'b1; tick(); reset = 1'b0; sample();
    chk("t6_after_done_ready", 64'(ia.trace_ready), 1);
    chk("t6_error_cleared", 64'(ia.resp_error), 0);
    tick(); offer(1'b0, 4'b1111, 1'b0, 4'b0011, 8'h66); sample();
    tick(); withdraw(1'b0); sample(); chk("t6_n1_lane", 64'(ia.req_lane), 0);
    tick(); sample(); chk("t6_n2_lane", 64'(ia.req_lane), 1);
    tick(); ia.req_ready = 1'b0; sample();
    chk("t6_pending_lane", 64'(ia.req_lane), 2);
    chk("t6_pending_outstanding", 64'(ia.outstanding), 2);
    tick(); reset = 1'b1; sample();
    chk("t6_rst_trace_ready", 64'(ia.trace_ready), 0);
    chk("t6_rst_req_valid", 64'(ia.req_valid), 0);
    chk("t6_rst_outstanding", 64'(ia.outstanding), 0);
    chk("t6_rst_busy", 64'(ia.busy), 0);
    chk("t6_rst_req_address", ia.req_address, 0);
    tick(); reset = 1'b0; ia.req_ready = 1'b1; sample();
    chk("t6_idle_ready", 64'(ia.trace_ready), 1);
    chk("t6_idle_outstanding", 64'(ia.outstanding), 0);
    chk("t6_idle_no_req", 64'(ia.req_valid), 0);
    tick(); sample();
    chk("t6_no_replay", 64'(ia.req_valid), 0);

    // 3: MAX_OUTSTANDING=2 instance, throttled by responses
    tick(); offer(1'b1, 4'b1111, 1'b0, 4'b1111, 8'h33); sample();
    chk("t3_accept_ready", 64'(ib.trace_ready), 1);
    tick(); withdraw(1'b1); sample(); chk("t3_n1_lane", 64'(ib.req_lane), 0);
    tick(); sample(); chk("t3_n2_lane", 64'(ib.req_lane), 1);
    tick(); sample();
    chk("t3_n3_throttled", 64'(ib.req_valid), 0);
    chk("t3_n3_outstanding", 64'(ib.outstanding), 2);
    tick(); ib.resp_valid = 1'b1; sample(); chk("t3_n4_throttled", 64'(ib.req_valid), 0);
    tick(); ib.resp_valid = 1'b0; sample();
    chk("t3_n5_valid", 64'(ib.req_valid), 1);
    chk("t3_n5_lane", 64'(ib.req_lane), 2);
    chk("t3_n5_outstanding", 64'(ib.outstanding), 1);
    tick(); sample();
    chk("t3_n6_throttled", 64'(ib.req_valid), 0);
    chk("t3_n6_outstanding", 64'(ib.outstanding), 2);
    tick(); ib.resp_valid = 1'b1; sample(); chk("t3_n7_throttled", 64'(ib.req_valid), 0);
    tick(); sample();
    chk("t3_n8_lane", 64'(ib.req_lane), 3);
    chk("t3_n8_outstanding", 64'(ib.outstanding), 1);
    tick(); ib.resp_valid = 1'b0; sample();
    chk("t3_n9_outstanding", 64'(ib.outstanding), 1);
    chk("t3_n9_ready", 64'(ib.trace_ready), 1);
    tick(); ib.resp_valid = 1'b1; sample();
    tick(); ib.resp_valid = 1'b0; sample();
    chk("t3_drained", 64'(ib.outstanding), 0);
    chk("t3_no_error", 64'(ib.resp_error), 0);

    tick(); sample();
    chk("a_queue_empty", 64'(exp_a.size()), 0);
    chk("b_queue_empty", 64'(exp_b.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
